// File: rtl/rr_grant_arbiter.sv
// ============================================================================
// rr_grant_arbiter : round-robin arbiter, registered one-hot grant, bounded
//                    hold time and a one-cycle gap between grants. Rev 1.0
// ============================================================================
`default_nettype none

module rr_grant_arbiter #(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 8,
  parameter int ID_W     = $clog2(N_REQ),
  parameter int HOLD_W   = $clog2(MAX_HOLD + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  request,
  output logic [N_REQ-1:0]  grant,
  output logic              grant_valid,
  output logic [ID_W-1:0]   grant_id,
  output logic [HOLD_W-1:0] hold_cnt,
  output logic              preempt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [ID_W:0]     C_N_REQ_W    = (ID_W + 1)'(N_REQ);
  localparam logic [ID_W-1:0]   C_LAST_RST   = ID_W'(N_REQ - 1);
  localparam logic [HOLD_W-1:0] C_MAX_HOLD_W = HOLD_W'(MAX_HOLD);

  state_t              state_q, state_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic                valid_q, valid_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ID_W-1:0]     last_q, last_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                preempt_q, preempt_d;

  logic                arb_found;
  logic [ID_W-1:0]     arb_sel;
  logic [ID_W:0]       arb_sum;
  logic                others_pending;

  // Search upward from last_q+1 with wrap; the last winner ends up lowest.
  always_comb begin
    arb_found = 1'b0;
    arb_sel   = '0;
    arb_sum   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      arb_sum = {1'b0, last_q} + (ID_W + 1)'(k);
      if (arb_sum >= C_N_REQ_W) begin
        arb_sum = arb_sum - C_N_REQ_W;
      end
      if (!arb_found && request[arb_sum[ID_W-1:0]]) begin
        arb_found = 1'b1;
        arb_sel   = arb_sum[ID_W-1:0];
      end
    end
  end

  assign others_pending = |(request & ~grant_q);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    valid_d   = valid_q;
    id_d      = id_q;
    last_d    = last_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;

    unique case (state_q)
      GRANT: begin
        if (!request[id_q] || ((hold_q == C_MAX_HOLD_W) && others_pending)) begin
          // Release wins over the hold limit, so preempt only on a live request.
          preempt_d = request[id_q];
          state_d   = GAP;
          grant_d   = '0;
          valid_d   = 1'b0;
          id_d      = '0;
          hold_d    = '0;
        end else if (hold_q == C_MAX_HOLD_W) begin
          hold_d = HOLD_W'(1);
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        if (arb_found) begin
          state_d = GRANT;
          grant_d = N_REQ'(1) << arb_sel;
          valid_d = 1'b1;
          id_d    = arb_sel;
          last_d  = arb_sel;
          hold_d  = HOLD_W'(1);
        end else begin
          state_d = IDLE;
          grant_d = '0;
          valid_d = 1'b0;
          id_d    = '0;
          hold_d  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      id_q      <= '0;
      last_q    <= C_LAST_RST;
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      id_q      <= id_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = valid_q;
  assign grant_id    = id_q;
  assign hold_cnt    = hold_q;
  assign preempt     = preempt_q;

endmodule

`default_nettype wire

// File: doc/rr_grant_arbiter.md
Name: rr_grant_arbiter

Overview:
- Round-robin request/grant arbiter with registered one-hot grants.
- Sits directly upstream of the request/grant consumer and its immediate-assertion checks.
- Drives the per-requester `grant` that the consumer qualifies with `request`.
- Enforces a bounded hold time and a one-cycle turnaround gap between grants.

Parameters:
- N_REQ, 4: number of requesters (2..16).
- MAX_HOLD, 8: maximum consecutive grant cycles before forced rotation when other requests are pending (≥2).
- ID_W, $clog2(N_REQ): width of grant_id (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- request  in  N_REQ  per-requester request level; bit i belongs to requester i.
- grant  out  N_REQ  registered one-hot grant; all-zero when no grant is active.
- grant_valid  out  1  OR of grant.
- grant_id  out  ID_W  index of the granted requester; 0 when grant_valid=0.
- hold_cnt  out  $clog2(MAX_HOLD+1)  cycles the current grant has been held, starting at 1 in the first grant cycle.
- preempt  out  1  one-cycle pulse when a grant is removed by the hold limit.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; grant=0, grant_valid=0, grant_id=0, hold_cnt=0, preempt=0; round-robin pointer last_id=N_REQ-1, so requester 0 has first priority.
- Reset mid-grant drops grant after that same edge. There is no GAP cycle after reset.
- All outputs are registered; no combinational path from request to any output.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If request≠0 at an edge, select the first set bit searching upward from last_id+1 with wrap-around.
  - After that edge: grant[sel]=1, grant_id=sel, hold_cnt=1, last_id=sel, state→GRANT.
  - Latency: request sampled at edge E → grant visible after E (1 cycle).
  - If request=0, remain in IDLE.
- GRANT (granted id g):
  - a) request[g]=0 at an edge → grant=0 after that edge, hold_cnt=0, state→GAP.
  - b) Else if hold_cnt==MAX_HOLD and any other request bit is set → grant=0, preempt=1 for one cycle, hold_cnt=0, state→GAP.
  - c) Else if hold_cnt==MAX_HOLD and no other request → keep grant, hold_cnt wraps to 1. No preempt.
  - d) Otherwise keep grant and increment hold_cnt.
  - Rule (a) has priority over (b): release and limit in the same cycle give no preempt.
- GAP:
  - Exactly one cycle with grant=0.
  - At the GAP edge, arbitrate exactly as in IDLE: grant after that edge if request≠0, else state→IDLE.
  - The previously granted requester has the lowest priority, because the search starts at last_id+1.
- Invariants:
  - grant is always one-hot or zero.
  - A grant is never asserted to a requester whose request was 0 at the deciding edge.
  - There are never two consecutive grant cycles belonging to different requesters.
- Requests that drop while not granted are simply ignored. There is no request latching.

Test Plan:
- Reset release, request=4'b0000 for 5 cycles → grant=0, grant_valid=0, grant_id=0, hold_cnt=0, preempt=0 every cycle.
- request=4'b0001 from cycle 2, dropped at cycle 6:
  - grant=4'b0001 from cycle 3, with hold_cnt 1,2,3,4.
  - grant=0 at cycle 7 (GAP), then IDLE.
- request=4'b1111 held constant, MAX_HOLD=8:
  - Grants rotate 0→1→2→3→0, each lasting 8 cycles and separated by a 1-cycle gap.
  - preempt pulses on each gap.
  - Check the hold_cnt sequence 1..8.
- request=4'b0100 only, held 20 cycles:
  - grant=4'b0100 continuously, no gap, preempt never high.
  - hold_cnt wraps 8→1.
- Requester 1 granted; in its 8th cycle request[1] drops while request[3] is high:
  - GAP without preempt.
  - Then grant=4'b1000, grant_id=3.
- rst_n=0 asserted for 1 cycle while grant=4'b0010 and hold_cnt=5:
  - All outputs zero after that edge.
  - With request=4'b0011 on release, grant=4'b0001 on the next edge (pointer reset).
